led_event_sequencer: RTL and testbench
======================================

// Module: led_event_sequencer
// PURPOSE
//  Sits directly upstream of the RGB status-LED driver and feeds its unit/event inputs.
//  Accepts fault/pick/drop events from the bot controller over a valid/ready handshake.
//  Buffers them in a small FIFO and shows them one at a time.
//  Each event holds its one-hot flag for HOLD_CYCLES, then all flags go low for GAP_CYCLES.
// PARAMETERS
//  HOLD_CYCLES  50_000_000  clocks an event flag stays high (1 s @ 50 MHz); must be >=1
//  GAP_CYCLES   5_000_000   clocks all flags stay low between events; must be >=1
//  DEPTH        4           FIFO entries; power of two, >=2
//  CNT_W        26          dwell counter width; must hold max(HOLD_CYCLES,GAP_CYCLES)-1
// PORTS
//  clk_50M    in   1  system clock, all logic on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  ev_valid   in   1  event offered this cycle
//  ev_ready   out  1  FIFO can accept; equals !full, combinational from FIFO count
//  ev_unit    in   2  unit index 0..2; 3 is illegal
//  ev_type    in   2  1=i_fault, 2=p_block, 3=b_drop; 0 is illegal
//  unitlist   out  2  unit index of the event being shown
//  i_fault    out  1  event flag, one-hot with p_block/b_drop
//  p_block    out  1  event flag
//  b_drop     out  1  event flag
//  busy       out  1  high in SHOW or GAP, or when the FIFO is non-empty
//  err_ill    out  1  one-cycle pulse when an illegal event is accepted
//  overflow   out  1  sticky; set when ev_valid is high and ev_ready is low; cleared by reset only
// BEHAVIOUR
//  Reset values: unitlist=0, all flags=0, busy=0, err_ill=0, overflow=0; FIFO empty; state=IDLE.
//  Handshake:
//   - Transfer occurs on a rising edge where ev_valid&&ev_ready.
//   - ev_unit and ev_type are sampled at that edge.
//  Illegal events (unit==3 or type==0) are accepted but never written; err_ill pulses the next cycle.
//  FIFO:
//   - Push and pop in the same cycle are both honoured; count is unchanged.
//   - Pointers wrap modulo DEPTH.
//   - When full, ev_ready=0 and no write occurs.
//  FSM is registered with three states: IDLE, SHOW, GAP.
//   IDLE:
//    - If FIFO non-empty: pop the head, load the outputs from it, set cnt=HOLD_CYCLES-1, go to SHOW.
//    - The outputs update on the same edge as the pop.
//   SHOW:
//    - Exactly one flag is high and unitlist=head unit; cnt decrements each clock.
//    - At cnt==0: clear all flags, set cnt=GAP_CYCLES-1, go to GAP.
//   GAP:
//    - All flags are 0 and unitlist holds its last value; cnt decrements.
//    - At cnt==0 go to IDLE.
//  Flag-high duration is exactly HOLD_CYCLES clocks.
//  Minimum spacing between flag rising edges is HOLD_CYCLES+GAP_CYCLES+1 clocks.
//  Latency: an event accepted at edge N into an empty, idle block drives its flag from edge N+1.
//  Events are shown strictly in acceptance order; none is lost unless overflow is set.
//  Input changes never alter an event already being shown.
//  Reset mid-SHOW or mid-GAP: outputs go to reset values immediately and buffered events are discarded.
// TESTING (HOLD_CYCLES=4, GAP_CYCLES=2, DEPTH=4)
//  1. reset, then unit=1 type=1 accepted at edge 0 -> i_fault=1, unitlist=1 on edges 1..4, 0 from edge 5, IDLE at edge 7.
//  2. back-to-back pushes (0,2),(2,3) -> p_block/unit0 shown first, then after 2-cycle gap b_drop/unit2; order kept.
//  3. five pushes while SHOW stalls the pop -> ev_ready=0 after the 4th; 5th with valid held sets overflow=1 and writes nothing.
//  4. push unit=3 type=1, then type=0 -> err_ill pulses once each; flags stay 0 and FIFO stays empty.
//  5. reset asserted during cycle 2 of SHOW with 2 queued -> flags 0 immediately; no event shown after release.
//  6. push on the same edge as the IDLE pop with FIFO at count 1 -> count stays 1; the new entry is shown next.

Source files
------------

// File: rtl/led_event_sequencer.sv
// Event sequencer for the RGB status LED: buffers fault/pick/drop events in a
// small FIFO and shows each as a one-hot flag for HOLD_CYCLES, then a GAP_CYCLES blank.
module led_event_sequencer #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 5_000_000,
   parameter int DEPTH       = 4,
   parameter int CNT_W       = 26
) (
   input  logic       clk_50M,
   input  logic       reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [1:0] ev_unit,
   input  logic [1:0] ev_type,
   output logic [1:0] unitlist,
   output logic       i_fault,
   output logic       p_block,
   output logic       b_drop,
   output logic       busy,
   output logic       err_ill,
   output logic       overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SHOW = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   // Each entry is {unit, type}.
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   logic             full;
   logic             empty;
   logic             accept;
   logic             legal;
   logic             push;
   logic             pop;
   logic [3:0]       head;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign ev_ready = !full;
   assign accept   = ev_valid && ev_ready;
   assign legal    = (ev_unit != 2'd3) && (ev_type != 2'd0);
   // Illegal events complete the handshake but never occupy a slot.
   assign push     = accept && legal;
   assign pop      = (state == IDLE) && !empty;
   assign head     = mem[rd_ptr];
   assign busy     = (state != IDLE) || !empty;

   // NOTE: the storage array has no reset; pointers and count define validity,
   // so clearing them is enough and the array can map onto plain RAM/registers.
   always_ff @(posedge clk_50M) begin
      if (push) mem[wr_ptr] <= {ev_unit, ev_type};
   end

   // NOTE: every sequential block uses non-blocking assignments so all flops
   // see pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         err_ill  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         err_ill  <= accept && !legal;
         overflow <= overflow || (ev_valid && !ev_ready);
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         unitlist <= 2'd0;
         i_fault  <= 1'b0;
         p_block  <= 1'b0;
         b_drop   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  unitlist <= head[3:2];
                  i_fault  <= (head[1:0] == 2'd1);
                  p_block  <= (head[1:0] == 2'd2);
                  b_drop   <= (head[1:0] == 2'd3);
                  cnt      <= HOLD_LOAD;
                  state    <= SHOW;
               end
            end
            SHOW: begin
               if (cnt == '0) begin
                  i_fault <= 1'b0;
                  p_block <= 1'b0;
                  b_drop  <= 1'b0;
                  cnt     <= GAP_LOAD;
                  state   <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_event_sequencer.sv
// Self-checking bench for led_event_sequencer: directed scenarios plus random
// traffic, compared each cycle against a queue-and-timeline reference model.
module tb_led_event_sequencer;

   localparam int H = 4;
   localparam int G = 2;
   localparam int D = 4;

   logic       clk_50M  = 1'b0;
   logic       reset    = 1'b0;
   logic       ev_valid = 1'b0;
   logic [1:0] ev_unit  = 2'd0;
   logic [1:0] ev_type  = 2'd0;
   logic       ev_ready;
   logic [1:0] unitlist;
   logic       i_fault;
   logic       p_block;
   logic       b_drop;
   logic       busy;
   logic       err_ill;
   logic       overflow;

   led_event_sequencer #(
      .HOLD_CYCLES(H), .GAP_CYCLES(G), .DEPTH(D), .CNT_W(4)
   ) dut (
      .clk_50M (clk_50M),
      .reset   (reset),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_unit (ev_unit),
      .ev_type (ev_type),
      .unitlist(unitlist),
      .i_fault (i_fault),
      .p_block (p_block),
      .b_drop  (b_drop),
      .busy    (busy),
      .err_ill (err_ill),
      .overflow(overflow)
   );

   always #5 clk_50M = ~clk_50M;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a queue of pending events plus the edge index at which
   // the current event started being shown. Display phase is derived from time.
   logic [3:0] m_q[$];
   int         cyc    = 0;
   int         start  = 0;
   bit         active = 1'b0;
   logic [1:0] sh_u   = 2'd0;
   logic [1:0] sh_t   = 2'd0;
   logic       m_err  = 1'b0;
   logic       m_ovf  = 1'b0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_flags();
      if (active && (cyc - start) < H) return 3'b100 >> (int'(sh_t) - 1);
      return 3'b000;
   endfunction

   function automatic logic exp_busy();
      return (active && cyc < start + H + G) || (m_q.size() > 0);
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".flags"},    {1'b0, i_fault, p_block, b_drop}, {1'b0, exp_flags()});
      check({tag, ".unitlist"}, {2'b0, unitlist}, {2'b0, sh_u});
      check({tag, ".busy"},     {3'b0, busy},     {3'b0, exp_busy()});
      check({tag, ".err_ill"},  {3'b0, err_ill},  {3'b0, m_err});
      check({tag, ".overflow"}, {3'b0, overflow}, {3'b0, m_ovf});
   endtask

   // Advance the model by one rising edge using the pre-edge state.
   task automatic model_edge(input logic v, input logic [1:0] u, input logic [1:0] t);
      bit rdy;
      bit idle_pre;
      bit lgl;
      logic [3:0] e;
      cyc++;
      rdy      = (m_q.size() < D);
      idle_pre = !active || (cyc > start + H + G);
      if (idle_pre && m_q.size() > 0) begin
         e      = m_q.pop_front();
         sh_u   = e[3:2];
         sh_t   = e[1:0];
         start  = cyc;
         active = 1'b1;
      end
      lgl = (u != 2'd3) && (t != 2'd0);
      if (v && rdy && lgl) m_q.push_back({u, t});
      m_err = v && rdy && !lgl;
      if (v && !rdy) m_ovf = 1'b1;
   endtask

   // Called at posedge+1: drive inputs, check ready, take the edge, check outputs.
   task automatic step(input logic v, input logic [1:0] u, input logic [1:0] t);
      ev_valid = v;
      ev_unit  = u;
      ev_type  = t;
      #1;
      check("ev_ready", {3'b0, ev_ready}, {3'b0, (m_q.size() < D)});
      model_edge(v, u, t);
      @(posedge clk_50M);
      #1;
      check_outputs("post");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      reset    = 1'b1;
      ev_valid = 1'b0;
      #1;
      m_q.delete();
      active = 1'b0;
      sh_u   = 2'd0;
      sh_t   = 2'd0;
      m_err  = 1'b0;
      m_ovf  = 1'b0;
      check_outputs("reset");
      check("reset.ev_ready", {3'b0, ev_ready}, 4'h1);
      @(posedge clk_50M);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int p;
      logic       v;
      logic [1:0] u;
      logic [1:0] t;

      #2;
      // Single event: i_fault/unit1 for 4 edges, gap, back to idle.
      do_reset();
      step(1'b1, 2'd1, 2'd1);
      idle(9);

      // Back-to-back pushes keep order across the gap.
      step(1'b1, 2'd0, 2'd2);
      step(1'b1, 2'd2, 2'd3);
      idle(16);

      // Fill the FIFO while showing, then overflow with valid held.
      step(1'b1, 2'd0, 2'd1);
      step(1'b1, 2'd1, 2'd2);
      step(1'b1, 2'd2, 2'd3);
      step(1'b1, 2'd0, 2'd3);
      step(1'b1, 2'd1, 2'd1);
      step(1'b1, 2'd2, 2'd2);
      step(1'b1, 2'd2, 2'd2);
      idle(40);

      // Illegal events pulse err_ill and are never shown.
      do_reset();
      step(1'b1, 2'd3, 2'd1);
      step(1'b1, 2'd1, 2'd0);
      idle(4);

      // Reset in the middle of SHOW with two events queued.
      step(1'b1, 2'd0, 2'd1);
      step(1'b1, 2'd1, 2'd2);
      step(1'b1, 2'd2, 2'd3);
      do_reset();
      idle(12);

      // Push on the same edge as the IDLE pop with one entry queued.
      step(1'b1, 2'd0, 2'd1);
      step(1'b0, 2'd0, 2'd0);
      step(1'b1, 2'd1, 2'd2);
      while (!((cyc + 1 > start + H + G) && m_q.size() == 1) && cyc < 1000)
         step(1'b0, 2'd0, 2'd0);
      step(1'b1, 2'd2, 2'd3);
      idle(20);

      // Random traffic at several offered loads.
      for (int c = 0; c < 4; c++) begin
         do_reset();
         p = 2 + 3 * c;
         for (int i = 0; i < 150; i++) begin
            v = ($urandom_range(0, p - 1) == 0);
            u = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            t = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            step(v, u, t);
         end
         idle(40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
